// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the parametrised sequence generator.
// Holds the FSM state encoding, the one-hot LED patterns and first terms.
package seq_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIB,
        ST_TRI,
        ST_SQR,
        ST_OVF
    } state_e;

    localparam logic [4:0] LED_IDLE = 5'b00001;
    localparam logic [4:0] LED_FIB  = 5'b00010;
    localparam logic [4:0] LED_TRI  = 5'b00100;
    localparam logic [4:0] LED_SQR  = 5'b01000;
    localparam logic [4:0] LED_OVF  = 5'b10000;

    // Fibonacci starts at 0 with a hidden predecessor of 1 so the second term is 1.
    localparam int FIRST_FIB     = 0;
    localparam int FIB_PREV_INIT = 1;
    localparam int FIRST_TRI     = 1;
    localparam int FIRST_SQR     = 1;
    localparam int FIRST_INDEX   = 1;

    function automatic logic [4:0] led_of(input state_e s);
        logic [4:0] led;
        led = LED_IDLE;
        case (s)
            ST_IDLE: led = LED_IDLE;
            ST_FIB:  led = LED_FIB;
            ST_TRI:  led = LED_TRI;
            ST_SQR:  led = LED_SQR;
            ST_OVF:  led = LED_OVF;
            default: led = LED_IDLE;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/tick_div.sv
// Programmable pace divider: one-cycle tick every (prog_reg+1)*DIV_BASE cycles.
// The period is sampled only on reload, so a prog change never cuts an interval short.
module tick_div #(
    parameter int PROG_W   = 3,
    parameter int DIV_BASE = 100000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic [PROG_W-1:0] prog_reg,
    output logic              tick
);

    localparam int CNT_RAW = $clog2((2 ** PROG_W) * DIV_BASE);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] reload;
    logic [31:0]      period;

    always_comb begin
        period = (32'(prog_reg) + 32'd1) * 32'(DIV_BASE);
        reload = CNT_W'(period - 32'd1);
        tick   = (cnt_q == '0);
        if (restart || tick) begin
            cnt_d = reload;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_gen_param.sv
// Fibonacci / triangular / squares sequencer with programmable pace.
// Terms are computed one bit wider than W so overflow can freeze the block in OVF.
module seq_gen_param
    import seq_gen_pkg::*;
#(
    parameter int W        = 16,
    parameter int PROG_W   = 3,
    parameter int DIV_BASE = 100000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_f,
    input  logic              start_t,
    input  logic              start_s,
    input  logic              stop_f_t,
    input  logic              update,
    input  logic [PROG_W-1:0] prog,
    output logic [W-1:0]      value,
    output logic              valid,
    output logic              ovf,
    output logic              parity,
    output logic [4:0]        led
);

    state_e            state_q, state_d;
    logic              first_q, first_d;
    logic [W-1:0]      value_q, value_d;
    logic [W-1:0]      prev_q, prev_d;
    logic [W-1:0]      n_q, n_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic [PROG_W-1:0] prog_q, prog_d;
    logic [4:0]        led_q, led_d;
    logic [W:0]        next_term;
    logic              tick;
    logic              restart;

    tick_div #(
        .PROG_W  (PROG_W),
        .DIV_BASE(DIV_BASE)
    ) u_tick_div (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .prog_reg(prog_q),
        .tick    (tick)
    );

    always_comb begin
        next_term = '0;
        case (state_q)
            ST_FIB:  next_term = {1'b0, prev_q} + {1'b0, value_q};
            ST_TRI:  next_term = {1'b0, value_q} + {1'b0, n_q} + (W + 1)'(1);
            ST_SQR:  next_term = {1'b0, value_q} + {n_q, 1'b0} + (W + 1)'(1);
            default: next_term = '0;
        endcase
    end

    // first_q marks the cycle after a start: the first term loads and the divider restarts.
    always_comb begin
        state_d = state_q;
        first_d = first_q;
        value_d = value_q;
        prev_d  = prev_q;
        n_d     = n_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q;
        prog_d  = update ? prog : prog_q;
        restart = 1'b0;

        if (stop_f_t) begin
            state_d = ST_IDLE;
            first_d = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_f) begin
                        state_d = ST_FIB;
                        first_d = 1'b1;
                    end else if (start_t) begin
                        state_d = ST_TRI;
                        first_d = 1'b1;
                    end else if (start_s) begin
                        state_d = ST_SQR;
                        first_d = 1'b1;
                    end
                end
                ST_FIB, ST_TRI, ST_SQR: begin
                    if (first_q) begin
                        first_d = 1'b0;
                        restart = 1'b1;
                        valid_d = 1'b1;
                        n_d     = W'(FIRST_INDEX);
                        prev_d  = W'(FIB_PREV_INIT);
                        case (state_q)
                            ST_FIB:  value_d = W'(FIRST_FIB);
                            ST_TRI:  value_d = W'(FIRST_TRI);
                            default: value_d = W'(FIRST_SQR);
                        endcase
                    end else if (tick) begin
                        if (next_term[W]) begin
                            state_d = ST_OVF;
                            ovf_d   = 1'b1;
                        end else begin
                            value_d = next_term[W-1:0];
                            valid_d = 1'b1;
                            prev_d  = value_q;
                            n_d     = n_q + W'(1);
                        end
                    end
                end
                ST_OVF: begin
                    state_d = ST_OVF;
                end
                default: begin
                    state_d = ST_IDLE;
                    first_d = 1'b0;
                end
            endcase
        end

        led_d = led_of(state_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            first_q <= 1'b0;
            value_q <= '0;
            prev_q  <= '0;
            n_q     <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            prog_q  <= '0;
            led_q   <= LED_IDLE;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            value_q <= value_d;
            prev_q  <= prev_d;
            n_q     <= n_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            prog_q  <= prog_d;
            led_q   <= led_d;
        end
    end

    assign value  = value_q;
    assign valid  = valid_q;
    assign ovf    = ovf_q;
    assign parity = ^value_q;
    assign led    = led_q;

endmodule
